// File: rtl/avalon_master_bridge_if.sv
// Command, response and Avalon-MM bus signals of the master bridge.
// The master modport is the bridge's view; the slave modport is the view of
// whatever drives commands and models the bus slave.
interface avalon_master_bridge_if #(
    parameter int ADDRESSWIDTH = 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDRESSWIDTH-1:0] cmd_address;
    logic [31:0]             cmd_data;

    logic                    rsp_valid;
    logic [31:0]             rsp_data;
    logic                    rsp_error;
    logic                    busy;

    logic [ADDRESSWIDTH-1:0] avm_address;
    logic                    avm_read;
    logic                    avm_write;
    logic [31:0]             avm_writedata;
    logic                    avm_waitrequest;
    logic [31:0]             avm_readdata;
    logic                    avm_readdatavalid;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_data,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output cmd_ready, rsp_valid, rsp_data, rsp_error, busy,
        output avm_address, avm_read, avm_write, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_data,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error, busy,
        input  avm_address, avm_read, avm_write, avm_writedata
    );
endinterface

// File: rtl/avalon_master_bridge.sv
// Avalon-MM master bridge: one single-word read or write in flight at a time,
// one response pulse per command, with a watchdog that aborts stuck transfers.
//
// state  | meaning
// IDLE   | ready for a command
// ISSUE  | strobe on the bus, waiting for waitrequest to drop
// RDWAIT | read accepted by the slave, waiting for readdatavalid
// RESP   | rsp_valid pulse, back to IDLE next cycle
module avalon_master_bridge #(
    parameter int ADDRESSWIDTH = 8,
    parameter int TIMEOUT      = 255
) (
    input logic clk,
    input logic reset,
    avalon_master_bridge_if.master bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    // The watchdog fires on the edge that would take the count to TIMEOUT.
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = TO_EN ? CW'(TIMEOUT) : '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state;
    logic                    wr_q;
    logic [ADDRESSWIDTH-1:0] addr_q;
    logic [31:0]             data_q;
    logic [CW-1:0]           cnt;
    logic                    avm_read_q;
    logic                    avm_write_q;
    logic                    rsp_valid_q;
    logic [31:0]             rsp_data_q;
    logic                    rsp_error_q;

    logic [CW-1:0] cnt_inc;
    logic          timeout_hit;

    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign timeout_hit = TO_EN && (cnt == CNT_LAST);

    assign bus.cmd_ready     = (state == IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.avm_address   = addr_q;
    assign bus.avm_writedata = data_q;
    assign bus.avm_read      = avm_read_q;
    assign bus.avm_write     = avm_write_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_error     = rsp_error_q;

    // Transfer sequencing, bus strobes, watchdog and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cnt         <= '0;
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        wr_q        <= bus.cmd_write;
                        addr_q      <= bus.cmd_address;
                        data_q      <= bus.cmd_data;
                        cnt         <= '0;
                        avm_read_q  <= !bus.cmd_write;
                        avm_write_q <= bus.cmd_write;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= cnt_inc;
                    // A write finishing on the watchdog edge still counts as done.
                    if (!bus.avm_waitrequest && wr_q) begin
                        avm_write_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_error_q <= 1'b0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        avm_read_q  <= 1'b0;
                        avm_write_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_error_q <= 1'b1;
                        state       <= RESP;
                    end else if (!bus.avm_waitrequest) begin
                        avm_read_q  <= 1'b0;
                        state       <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    cnt <= cnt_inc;
                    if (bus.avm_readdatavalid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= bus.avm_readdata;
                        rsp_error_q <= 1'b0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_error_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_master_bridge.sv
// Scoreboard bench for avalon_master_bridge: directed and random commands,
// a behavioural Avalon slave, and a monitor checking every response.
module tb_avalon_master_bridge;
    localparam int AW = 8;
    localparam int TO = 8;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    avalon_master_bridge_if #(.ADDRESSWIDTH(AW)) bus ();

    avalon_master_bridge #(.ADDRESSWIDTH(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          wr;
        logic [AW-1:0] addr;
        logic [31:0] data;
        int          w;
        int          lat;
        logic [31:0] rdata;
    } slv_t;

    typedef struct {
        bit          err;
        logic [31:0] data;
        int          at_edge;
    } exp_t;

    slv_t slv_q[$];
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_from = 1;
    int busy_to = 0;

    int rd_cd = 0;
    bit slv_active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: edges after the accept edge at which the response is
    // registered, and whether it is a timeout.
    function automatic int resp_offset(input bit wr, input int w, input int lat, output bit err);
        int done;
        if (wr) done = w + 1;
        else if (lat == 0) done = NEVER;
        else done = w + 1 + lat;
        if (done <= TO) begin
            err = 1'b0;
            return done;
        end
        err = 1'b1;
        return TO;
    endfunction

    function automatic bit model_busy(input int c);
        return (c >= busy_from) && (c <= busy_to);
    endfunction

    // Present a command (called at a negedge); returns at the negedge after the accept edge.
    task automatic do_cmd(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                          input int w, input int lat, input logic [31:0] rdata);
        int guard = 0;
        bit err;
        int off;
        exp_t e;
        slv_t s;
        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = wr;
        bus.cmd_address = a;
        bus.cmd_data    = d;
        while (model_busy(cyc) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", 32'(guard < 200), 32'd1);
        off = resp_offset(wr, w, lat, err);
        e.err = err;
        e.data = (wr || err) ? 32'd0 : rdata;
        e.at_edge = cyc + 1 + off;
        exp_q.push_back(e);
        s.wr = wr; s.addr = a; s.data = d; s.w = w; s.lat = lat; s.rdata = rdata;
        slv_q.push_back(s);
        busy_from = cyc + 1;
        busy_to = cyc + 1 + off;
        @(negedge clk);
    endtask

    task automatic idle_cmd();
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'($urandom);
        bus.cmd_address = AW'($urandom);
        bus.cmd_data    = $urandom;
    endtask

    task automatic wait_quiet();
        int g = 0;
        while ((exp_q.size() != 0 || rd_cd != 0 || slv_active || model_busy(cyc)) && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("quiet_wait", 32'(g < 100), 32'd1);
    endtask

    // Reset during a transfer; stall > 0 keeps the bridge in ISSUE, otherwise RDWAIT.
    task automatic reset_mid(input int stall);
        do_cmd(1'b0, 8'h44, 32'h0, stall, 0, 32'h1);
        idle_cmd();
        @(negedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        slv_q.delete();
        slv_active = 1'b0;
        rd_cd = 0;
        busy_from = 1;
        busy_to = 0;
        #1;
        chk("rstmid_avm_read", 32'(bus.avm_read), 32'd0);
        chk("rstmid_avm_write", 32'(bus.avm_write), 32'd0);
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // Behavioural Avalon slave: stalls w cycles, returns read data lat edges after acceptance.
    initial begin
        int wleft = 0;
        slv_t cur;
        logic [31:0] pend = 0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
        forever begin
            @(negedge clk);
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = $urandom;
            if (reset) begin
                rd_cd = 0;
                slv_active = 1'b0;
                bus.avm_waitrequest = 1'b0;
            end else begin
                if (rd_cd > 0) begin
                    rd_cd--;
                    if (rd_cd == 0) begin
                        bus.avm_readdatavalid = 1'b1;
                        bus.avm_readdata = pend;
                    end
                end
                if (bus.avm_read || bus.avm_write) begin
                    if (!slv_active) begin
                        chk("strobe_has_cmd", 32'(slv_q.size() != 0), 32'd1);
                        if (slv_q.size() != 0) begin
                            cur = slv_q.pop_front();
                            slv_active = 1'b1;
                            wleft = cur.w;
                        end
                    end
                    if (slv_active) begin
                        chk("avm_write", 32'(bus.avm_write), 32'(cur.wr));
                        chk("avm_read", 32'(bus.avm_read), 32'(!cur.wr));
                        chk("avm_address", 32'(bus.avm_address), 32'(cur.addr));
                        if (cur.wr) chk("avm_writedata", bus.avm_writedata, cur.data);
                        if (wleft > 0) begin
                            bus.avm_waitrequest = 1'b1;
                            wleft--;
                        end else begin
                            bus.avm_waitrequest = 1'b0;
                            slv_active = 1'b0;
                            if (!cur.wr && cur.lat > 0) begin
                                rd_cd = cur.lat;
                                pend = cur.rdata;
                            end
                        end
                    end else begin
                        bus.avm_waitrequest = 1'($urandom_range(0, 1));
                    end
                end else begin
                    slv_active = 1'b0;
                    bus.avm_waitrequest = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Monitor: handshake status every cycle, responses against the scoreboard.
    initial begin
        exp_t e;
        bit exp_ready;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_ready = !model_busy(cyc);
                chk("cmd_ready", 32'(bus.cmd_ready), 32'(exp_ready));
                chk("busy", 32'(bus.busy), 32'(!exp_ready));
                if (bus.rsp_valid) begin
                    chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rsp_cycle", 32'(cyc), 32'(e.at_edge));
                        chk("rsp_error", 32'(bus.rsp_error), 32'(e.err));
                        chk("rsp_data", bus.rsp_data, e.data);
                    end
                end else if (exp_q.size() != 0 && cyc >= exp_q[0].at_edge) begin
                    chk("rsp_missing", 32'(bus.rsp_valid), 32'd1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    // Stimulus.
    initial begin
        bit wr;
        int w;
        int lat;
        idle_cmd();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
        chk("rst_avm_read", 32'(bus.avm_read), 32'd0);
        chk("rst_avm_write", 32'(bus.avm_write), 32'd0);
        chk("rst_avm_address", 32'(bus.avm_address), 32'd0);
        chk("rst_avm_writedata", bus.avm_writedata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        do_cmd(1'b1, 8'h05, 32'h12345678, 0, 0, 32'h0);
        idle_cmd(); wait_quiet();
        do_cmd(1'b0, 8'h03, 32'h0, 0, 1, 32'hDEADBEEF);
        idle_cmd(); wait_quiet();
        do_cmd(1'b0, 8'h07, 32'h0, 3, 2, 32'hCAFEF00D);
        idle_cmd(); wait_quiet();
        do_cmd(1'b1, 8'h11, 32'hA5A5A5A5, 7, 0, 32'h0);
        idle_cmd(); wait_quiet();
        do_cmd(1'b0, 8'h12, 32'h0, 0, 7, 32'h0BADF00D);
        idle_cmd(); wait_quiet();
        do_cmd(1'b1, 8'h13, 32'h5A5A5A5A, 8, 0, 32'h0);
        idle_cmd(); wait_quiet();
        do_cmd(1'b0, 8'h21, 32'h0, 0, 10, 32'h55AA55AA);
        idle_cmd(); wait_quiet();
        do_cmd(1'b0, 8'h22, 32'h0, 0, 0, 32'h0);
        idle_cmd(); wait_quiet();
        do_cmd(1'b0, 8'h23, 32'h0, 1, 1, 32'h01020304);
        idle_cmd(); wait_quiet();

        for (int i = 0; i < 6; i++) begin
            wr = 1'($urandom);
            do_cmd(wr, AW'($urandom), $urandom, $urandom_range(0, 2), $urandom_range(1, 3), $urandom);
        end
        idle_cmd(); wait_quiet();

        reset_mid(0);
        do_cmd(1'b1, 8'h30, 32'h13579BDF, 0, 0, 32'h0);
        idle_cmd(); wait_quiet();
        reset_mid(5);
        do_cmd(1'b0, 8'h31, 32'h0, 0, 1, 32'h2468ACE0);
        idle_cmd(); wait_quiet();

        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom);
            w = $urandom_range(0, 4);
            lat = $urandom_range(0, 7);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_cmd(wr, AW'($urandom), $urandom, w, lat, $urandom);
            idle_cmd();
            wait_quiet();
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/avalon_master_bridge.md
Name: avalon_master_bridge

Overview:
- Avalon-MM master (initiator) that turns single-word read/write commands from local logic into Avalon bus transfers.
- Returns one response per command.
- Drives slave-side register adapters from processor-less test logic and DMA-style sequencers.
- One transfer outstanding at a time; honours waitrequest and variable-latency readdatavalid; has a timeout watchdog.

Parameters:
- ADDRESSWIDTH, 8, width of cmd_address and avm_address.
- TIMEOUT, 255, cycles allowed in ISSUE+RDWAIT before abort; 0 disables the watchdog.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  bridge can accept a command
- cmd_write  input  1  1=write, 0=read
- cmd_address  input  ADDRESSWIDTH  target word address
- cmd_data  input  32  write data
- rsp_valid  output  1  one-cycle response pulse
- rsp_data  output  32  read data; 0 for writes and errors
- rsp_error  output  1  timeout abort, qualified by rsp_valid
- busy  output  1  state != IDLE
- avm_address  output  ADDRESSWIDTH  bus address
- avm_read  output  1  bus read strobe
- avm_write  output  1  bus write strobe
- avm_writedata  output  32  bus write data
- avm_waitrequest  input  1  slave stall
- avm_readdata  input  32  slave read data
- avm_readdatavalid  input  1  slave read data qualifier

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0, except cmd_ready=1.
  - Timeout counter 0; captured address/data registers 0.
- Reset mid-operation aborts at once: bus strobes drop asynchronously and no response is generated.
- States: IDLE, ISSUE, RDWAIT, RESP.
- cmd_ready = (state==IDLE), combinational from state. A command is accepted on cmd_valid & cmd_ready.
- IDLE: on accept, register cmd_write, cmd_address, cmd_data; go to ISSUE; clear counter.
- ISSUE:
  - avm_read = !wr_q and avm_write = wr_q, both registered. avm_address and avm_writedata come from the captured registers and stay stable the whole time.
  - Strobe is held while avm_waitrequest=1.
  - When avm_waitrequest=0: the transfer is accepted that cycle and the strobe drops next cycle.
  - After acceptance, a write goes to RESP and a read goes to RDWAIT.
- RDWAIT:
  - On avm_readdatavalid=1, capture avm_readdata into rsp_data and go to RESP.
  - avm_readdatavalid is ignored in IDLE, ISSUE and RESP. Responses arriving after a timeout are discarded.
- RESP:
  - rsp_valid=1 for exactly one cycle; there is no response backpressure.
  - Return to IDLE next cycle, so cmd_ready=1 the cycle after the pulse.
- Timeout (TIMEOUT>0):
  - Counter increments each cycle in ISSUE or RDWAIT and saturates.
  - If it reaches TIMEOUT before completion: drop strobes, go to RESP with rsp_error=1 and rsp_data=0.
  - Completion and timeout in the same cycle: completion wins, error=0.
- Counter width is $clog2(TIMEOUT+1), minimum 1.
- Latency, with accept at cycle N:
  - Strobe high at N+1.
  - Zero-wait write: rsp_valid at N+2.
  - Zero-wait read with 1-cycle read latency: readdatavalid at N+2, rsp_valid at N+3.
  - Each waitrequest cycle adds 1.
- rsp_data and rsp_error hold their values until the next RESP. They are only meaningful with rsp_valid.
- cmd_valid while busy is ignored. The command must be held by the source until cmd_ready.

Test Plan:
- Write cmd addr=0x05, data=0x12345678, waitrequest=0 → avm_write high exactly 1 cycle at N+1 with addr 0x05 and data 0x12345678; rsp_valid at N+2 with rsp_error=0 and rsp_data=0.
- Read addr=0x03 against a 1-cycle-latency slave returning 0xDEADBEEF → avm_read 1 cycle at N+1; rsp_valid at N+3 with rsp_data=0xDEADBEEF.
- Read with waitrequest held 3 cycles, then readdatavalid 2 cycles after acceptance → avm_read high 4 cycles with stable address; rsp_valid at N+7 with correct data.
- TIMEOUT=8, read where readdatavalid never comes → rsp_valid with rsp_error=1 and rsp_data=0, 8 cycles after ISSUE entry; a late readdatavalid afterwards produces no response; next command proceeds normally.
- cmd_valid held continuously with back-to-back commands → exactly one accept per IDLE visit; cmd_ready low from accept until after rsp_valid; no command dropped or duplicated.
- Reset asserted while in RDWAIT → strobes, busy and rsp_valid all 0 immediately; cmd_ready=1; no response after reset releases.
